// File: rtl/pc_seq_pkg.sv
// Shared op encodings and default widths for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    PC_OP_HOLD   = 3'd0,
    PC_OP_INC    = 3'd1,
    PC_OP_BR_REL = 3'd2,
    PC_OP_JMP    = 3'd3,
    PC_OP_CALL   = 3'd4,
    PC_OP_RET    = 3'd5
  } pc_op_e;

  localparam int DEF_PC_W      = 6;
  localparam int DEF_OFF_W     = 6;
  localparam int DEF_RAS_DEPTH = 4;
  localparam int DEF_RESET_VEC = 0;

endpackage

// File: rtl/pc_ras.sv
// Return-address LIFO: push is ignored when full, pop is ignored when empty;
// the fill count never wraps.
module pc_ras #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [2**AW];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign wr_idx   = AW'(count);
  assign rd_idx   = AW'(count - CNT_W'(1));
  assign top_data = mem[rd_idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      count <= count - CNT_W'(1);
    end
  end

  // Storage is deliberately unreset; only entries below count are ever read.
  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Program counter with increment, relative branch, jump, call/return and a RAS.
// Breakpoint halt logic is built only when PC_BREAKPOINT_EN is defined.
module pc_seq_unit
  import pc_seq_pkg::*;
#(
  parameter int PC_W      = DEF_PC_W,
  parameter int OFF_W     = DEF_OFF_W,
  parameter int RAS_DEPTH = DEF_RAS_DEPTH,
  parameter int RESET_VEC = DEF_RESET_VEC
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           run,
  input  logic                           c3,
  input  logic [2:0]                     pc_op,
  input  logic [PC_W-1:0]                pc_target,
  input  logic [OFF_W-1:0]               br_offset,
  input  logic                           clr_err,
  input  logic                           bp_en,
  input  logic [PC_W-1:0]                bp_addr,
  input  logic                           resume,
  output logic [PC_W-1:0]                pc_reg,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_ovf,
  output logic                           ras_unf,
  output logic                           halted
);

  logic                   upd;
  logic                   do_op;
  logic                   bp_hit;
  logic                   halted_q;
  logic                   ras_push;
  logic                   ras_pop;
  logic                   ras_full;
  logic                   ras_empty;
  logic                   set_ovf;
  logic                   set_unf;
  logic [PC_W-1:0]        ras_top;
  logic [PC_W-1:0]        pc_inc;
  logic [PC_W-1:0]        pc_next;
  logic signed [PC_W-1:0] off_ext;

  assign pc_inc  = pc_reg + PC_W'(1);
  assign off_ext = PC_W'($signed(br_offset));
  assign upd     = run && c3 && !halted_q;
  assign do_op   = upd && !bp_hit;

  pc_ras #(
    .WIDTH (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top_data  (ras_top),
    .full      (ras_full),
    .empty     (ras_empty),
    .count     (ras_count)
  );

  // A CALL into a full stack still jumps; a RET from an empty stack falls through.
  always_comb begin
    pc_next  = pc_reg;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    if (do_op) begin
      case (pc_op)
        PC_OP_INC:    pc_next = pc_inc;
        PC_OP_BR_REL: pc_next = pc_inc + off_ext;
        PC_OP_JMP:    pc_next = pc_target;
        PC_OP_CALL: begin
          pc_next  = pc_target;
          ras_push = !ras_full;
          set_ovf  = ras_full;
        end
        PC_OP_RET: begin
          if (ras_empty) begin
            pc_next = pc_inc;
            set_unf = 1'b1;
          end else begin
            pc_next = ras_top;
            ras_pop = 1'b1;
          end
        end
        default: pc_next = pc_reg;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_reg  <= PC_W'(RESET_VEC);
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      pc_reg <= pc_next;
      if (set_ovf) begin
        ras_ovf <= 1'b1;
      end else if (run && clr_err) begin
        ras_ovf <= 1'b0;
      end
      if (set_unf) begin
        ras_unf <= 1'b1;
      end else if (run && clr_err) begin
        ras_unf <= 1'b0;
      end
    end
  end

`ifdef PC_BREAKPOINT_EN
  logic bp_skip;

  assign bp_hit = upd && bp_en && (pc_reg == bp_addr) && !bp_skip;

  // After resume the breakpoint stays disarmed until the PC actually moves.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      halted_q <= 1'b0;
      bp_skip  <= 1'b0;
    end else if (halted_q) begin
      if (run && resume) begin
        halted_q <= 1'b0;
        bp_skip  <= 1'b1;
      end
    end else if (bp_hit) begin
      halted_q <= 1'b1;
    end else if (pc_next != pc_reg) begin
      bp_skip <= 1'b0;
    end
  end
`else
  logic unused_bp;

  assign unused_bp = ^{bp_en, bp_addr, resume};
  assign bp_hit    = 1'b0;
  assign halted_q  = 1'b0;
`endif

  assign halted = halted_q;

endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
- Parametrised next-generation program counter for the i281 multicycle CPU family.
- Generalises the fixed 6-bit load-only PC to:
  - configurable address width;
  - increment, relative branch, absolute jump, call and return operations;
  - an internal return-address stack (RAS) of configurable depth.
- Sits between the control FSM (op select, update strobe) and instruction memory addressing (pc_reg).

Parameters:
- PC_W, 6, PC/address width in bits.
- OFF_W, 6, width of signed relative-branch offset (two's complement), OFF_W <= PC_W.
- RAS_DEPTH, 4, return-address stack entries (>= 1).
- RESET_VEC, 0, PC value loaded on reset.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- run  in  1  global run enable; no state change when 0.
- c3  in  1  PC update strobe from control unit; op executes only when run && c3.
- pc_op  in  3  operation: 0 HOLD, 1 INC, 2 BR_REL, 3 JMP, 4 CALL, 5 RET, 6-7 reserved (treated as HOLD).
- pc_target  in  PC_W  absolute target for JMP/CALL.
- br_offset  in  OFF_W  signed offset for BR_REL.
- clr_err  in  1  clears sticky error flags (synchronous, gated by run).
- bp_en  in  1  breakpoint enable (used only with PC_BREAKPOINT_EN).
- bp_addr  in  PC_W  breakpoint address (used only with PC_BREAKPOINT_EN).
- resume  in  1  releases breakpoint halt (used only with PC_BREAKPOINT_EN).
- pc_reg  out  PC_W  current program counter.
- ras_count  out  $clog2(RAS_DEPTH+1)  current number of valid RAS entries.
- ras_ovf  out  1  sticky: CALL issued with RAS full.
- ras_unf  out  1  sticky: RET issued with RAS empty.
- halted  out  1  breakpoint halt active.

Behaviour:
- Reset (async, any time, including mid-operation):
  - pc_reg=RESET_VEC; ras_count=0; ras_ovf=0; ras_unf=0; halted=0.
  - RAS contents are don't-care after reset.
- Update condition: upd = run && c3 && !halted. All ops take effect at the next rising edge; 1-cycle latency; pc_reg is a registered output.
- Operations (all PC arithmetic modulo 2^PC_W; wrap is silent, no flag):
  - HOLD: pc_reg unchanged.
  - INC: pc_reg <= pc_reg + 1.
  - BR_REL: pc_reg <= pc_reg + 1 + sign_extend(br_offset). Offset is relative to PC+1.
  - JMP: pc_reg <= pc_target.
  - CALL, RAS not full: push pc_reg+1; pc_reg <= pc_target; ras_count++.
  - CALL, RAS full: no push; ras_count unchanged; ras_ovf <= 1; pc_reg <= pc_target (the jump still happens).
  - RET, RAS not empty: pc_reg <= top entry; ras_count--.
  - RET, RAS empty: ras_unf <= 1; pc_reg <= pc_reg + 1; ras_count stays 0.
- clr_err (when run=1): clears ras_ovf/ras_unf. If an error event occurs in the same cycle, the set wins.
- c3 high with run=0: no effect. run/c3 are not latched.
- LIFO order strict; depth-1 configuration must work (single entry).

Optional Feature:
- Macro: PC_BREAKPOINT_EN.
- Defined:
  - When upd conditions are met (run && c3 && bp_en) and pc_reg==bp_addr, the op is suppressed: no PC/RAS/flag change; halted <= 1.
  - While halted, all ops are ignored.
  - resume=1 (with run=1) clears halted. The next upd executes normally, even at the same address (one-shot skip), so a breakpoint does not re-trigger until pc_reg changes.
- Undefined: bp_en, bp_addr and resume are ignored; halted is constant 0.

Decomposition:
- Package pc_seq_pkg: pc_op encoding constants (PC_OP_HOLD..PC_OP_RET) and default widths.
- Sub-module pc_ras: parametrised LIFO (push/pop/full/empty/count), async reset, and pointer with no wrap.

Test Plan:
- Reset then 3x INC with run=1, c3=1 -> pc_reg 0,1,2,3. Assert reset mid-sequence -> pc_reg=0 immediately, before the clock edge.
- PC_W=6, pc_reg=63, INC -> 0. pc_reg=10, BR_REL offset=-3 (6'b111101) -> 8. pc_reg=60, BR_REL +5 -> 2 (wrap).
- CALL target 20 from pc 5, CALL 30 from 20, then RET, RET -> pc 20, 30, 21, 6; ras_count 1,2,1,0.
- RAS_DEPTH=4: five nested CALLs -> fifth sets ras_ovf, ras_count=4, pc=target. Five RETs -> fifth sets ras_unf, pc increments. clr_err -> both 0.
- run=0 with c3=1 and op=JMP 40 -> pc unchanged. run=1, c3=0 -> unchanged. Reserved op 7 -> unchanged.
- PC_BREAKPOINT_EN, bp_addr=3: INC from 0 -> stops at 3 with halted=1 and pc stays 3 under repeated c3. resume -> next INC gives 4. Without the macro, the same stimulus reaches 5 with halted=0.
